// File: rtl/regfile_wb_buf_pkg.sv
// Shared definitions for the register-file write-back buffer: default widths,
// active-high / active-low enable levels and the port arbitration encoding.
package regfile_wb_buf_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 4;

   // Active-low enable levels (regfile we_)
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // Active-high enable levels
   localparam logic ENABLE   = 1'b1;
   localparam logic DISABLE  = 1'b0;

   // Owner of the regfile port in the current cycle
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_READ  = 2'b01,
      ARB_DRAIN = 2'b10
   } arb_state_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Write queue for regfile_wb_buf: circular storage, head/tail/count, and an
// address-match vector over the live entries (index 0 = oldest).
// Build option REGFILE_WB_FWD_EN adds the youngest-match data select output.
module regfile_wb_fifo
   import regfile_wb_buf_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        push_addr,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [ADDR_W-1:0]        head_addr,
   output logic [DATA_W-1:0]        head_data,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [ADDR_W-1:0]        match_addr,
`ifdef REGFILE_WB_FWD_EN
   output logic [DATA_W-1:0]        match_data,
`endif
   output logic                     match_any
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_mem_r [DEPTH];
   logic [DATA_W-1:0] data_mem_r [DEPTH];
   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [CNT_W-1:0]  count_r;
   logic [DEPTH-1:0]  match_vec_s;

   // Store the incoming entry at the tail slot
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem_r[i] <= '0;
            data_mem_r[i] <= '0;
         end
      end else if (push) begin
         addr_mem_r[tail_r] <= push_addr;
         data_mem_r[tail_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; push only when not full, pop only when not empty
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (push) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         if (pop) begin
            head_r <= head_r + PTR_W'(1);
         end
      end
   end

   // Age-ordered match of each live entry against the read address
   always_comb begin
      match_vec_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec_s[i] = (CNT_W'(i) < count_r) &&
                          (addr_mem_r[head_r + PTR_W'(i)] == match_addr);
      end
   end

`ifdef REGFILE_WB_FWD_EN
   // Youngest matching entry wins, so later writes override earlier ones
   always_comb begin
      match_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_data = match_vec_s[i] ? data_mem_r[head_r + PTR_W'(i)] : match_data;
      end
   end
`endif

   assign match_any = |match_vec_s;
   assign head_addr = addr_mem_r[head_r];
   assign head_data = data_mem_r[head_r];
   assign count     = count_r;

endmodule

// File: rtl/regfile_wb_buf.sv
// Write-back buffer in front of a single-port register file. Queues writes,
// arbitrates the regfile port between reads and the oldest queued write, and
// registers read results (latency 1).
// REGFILE_WB_FWD_EN: defined -> reads forward from the youngest matching queued
// write; undefined -> a matching read stalls until the matching writes drain.
module regfile_wb_buf
   import regfile_wb_buf_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [DATA_W-1:0] rf_d_in,
   output logic              rf_we_,
   input  logic [DATA_W-1:0] rf_d_out,
   output logic              idle
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0]  count_s;
   logic [ADDR_W-1:0] head_addr_s;
   logic [DATA_W-1:0] head_data_s;
   logic              match_any_s;
   logic              full_s;
   logic              empty_s;
   logic              stall_s;
   logic              push_s;
   logic              pop_s;
   arb_state_t        arb_s;
`ifdef REGFILE_WB_FWD_EN
   logic [DATA_W-1:0] match_data_s;
`endif

   regfile_wb_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_s),
      .push_addr  (wr_addr),
      .push_data  (wr_data),
      .pop        (pop_s),
      .head_addr  (head_addr_s),
      .head_data  (head_data_s),
      .count      (count_s),
      .match_addr (rd_addr),
`ifdef REGFILE_WB_FWD_EN
      .match_data (match_data_s),
`endif
      .match_any  (match_any_s)
   );

   assign full_s  = (count_s == CNT_W'(DEPTH));
   assign empty_s = (count_s == CNT_W'(0));
   assign idle    = empty_s;

   // Full check uses the registered count only: a pop this cycle does not free a slot
   assign wr_ready = !reset && !full_s;
   assign push_s   = wr_valid && wr_ready;

`ifdef REGFILE_WB_FWD_EN
   assign stall_s = 1'b0;
`else
   assign stall_s = match_any_s;
`endif

   // Choose the regfile port owner; a full queue drains ahead of reads so writes cannot starve
   always_comb begin
      arb_s = ARB_IDLE;
      if (reset) begin
         arb_s = ARB_IDLE;
      end else if (rd_valid && !full_s && !stall_s) begin
         arb_s = ARB_READ;
      end else if (!empty_s) begin
         arb_s = ARB_DRAIN;
      end else begin
         arb_s = ARB_IDLE;
      end
   end

   // Drive the regfile port and handshakes for the chosen owner
   always_comb begin
      rf_addr  = '0;
      rf_d_in  = '0;
      rf_we_   = DISABLE_;
      rd_ready = DISABLE;
      pop_s    = DISABLE;
      case (arb_s)
         ARB_READ: begin
            rd_ready = ENABLE;
            rf_addr  = rd_addr;
         end
         ARB_DRAIN: begin
            rf_addr  = head_addr_s;
            rf_d_in  = head_data_s;
            rf_we_   = ENABLE_;
            pop_s    = ENABLE;
         end
         default: begin
            rf_we_   = DISABLE_;
         end
      endcase
   end

   // Capture the read result at the accepting edge
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
      end else if (arb_s == ARB_READ) begin
         rd_data_valid <= 1'b1;
`ifdef REGFILE_WB_FWD_EN
         rd_data       <= match_any_s ? match_data_s : rf_d_out;
`else
         rd_data       <= rf_d_out;
`endif
      end else begin
         rd_data_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_buf.sv
// Directed bench for regfile_wb_buf with a behavioural single-port regfile.
// Expectations follow REGFILE_WB_FWD_EN the same way the design does.
module tb_regfile_wb_buf;

   logic        clk;
   logic        reset;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic [4:0]  rf_addr;
   logic [31:0] rf_d_in;
   logic        rf_we_;
   logic [31:0] rf_d_out;
   logic        idle;

   int n_vec;
   int n_miss;

   regfile_wb_buf #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .rf_addr       (rf_addr),
      .rf_d_in       (rf_d_in),
      .rf_we_        (rf_we_),
      .rf_d_out      (rf_d_out),
      .idle          (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural regfile: combinational read, write on we_ low; preloaded C000_0000+addr
   logic [31:0] rf_mem [32];
   logic        mdl_init;
   always @(posedge clk) begin
      if (mdl_init) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hC000_0000 + 32'(i);
      end else if (rf_we_ == 1'b0) begin
         rf_mem[rf_addr] <= rf_d_in;
      end
   end
   assign rf_d_out = rf_mem[rf_addr];

   typedef struct {
      logic        rst;
      logic        wv;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rv;
      logic [4:0]  ra;
      logic        e_wrr;
      logic        e_rdr;
      logic        e_we;
      logic [4:0]  e_rfa;
      logic [31:0] e_rfd;
      logic        e_idle;
      logic        e_rdv;
      logic [31:0] e_rdd;
   } vec_t;

   vec_t vt [12];

   function automatic vec_t mk(input logic rst, input logic wv, input logic [4:0] wa,
                               input logic [31:0] wd, input logic rv, input logic [4:0] ra,
                               input logic e_wrr, input logic e_rdr, input logic e_we,
                               input logic [4:0] e_rfa, input logic [31:0] e_rfd,
                               input logic e_idle, input logic e_rdv, input logic [31:0] e_rdd);
      vec_t v;
      v.rst = rst; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
      v.e_wrr = e_wrr; v.e_rdr = e_rdr; v.e_we = e_we; v.e_rfa = e_rfa; v.e_rfd = e_rfd;
      v.e_idle = e_idle; v.e_rdv = e_rdv; v.e_rdd = e_rdd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic wv, input logic [4:0] wa,
                        input logic [31:0] wd, input logic rv, input logic [4:0] ra);
      reset = rst; wr_valid = wv; wr_addr = wa; wr_data = wd; rd_valid = rv; rd_addr = ra;
   endtask

   task automatic wait_idle(input string nm);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         #1;
         seen = idle;
         @(negedge clk);
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      n_vec    = 0;
      n_miss   = 0;
      mdl_init = 1'b1;
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

      //      rst   wv    wa     wd            rv    ra     wrr   rdr   we_   rfa    rfd           idle  rdv   rdd
      vt[0]  = mk(1'b1, 1'b1, 5'd5,  32'h55,   1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  32'h0,    1'b1, 1'b0, 32'h0);
      vt[1]  = mk(1'b1, 1'b1, 5'd5,  32'h55,   1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  32'h0,    1'b1, 1'b0, 32'h0);
      vt[2]  = mk(1'b0, 1'b1, 5'd3,  32'h33,   1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  32'h0,    1'b1, 1'b0, 32'h0);
      vt[3]  = mk(1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd3,  32'h33,   1'b0, 1'b0, 32'h0);
      vt[4]  = mk(1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  1'b1, 1'b1, 1'b1, 5'd3,  32'h0,    1'b1, 1'b0, 32'h0);
      vt[5]  = mk(1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  1'b1, 1'b1, 1'b1, 5'd9,  32'h0,    1'b1, 1'b1, 32'h33);
      vt[6]  = mk(1'b0, 1'b1, 5'd12, 32'hCC,   1'b1, 5'd4,  1'b1, 1'b1, 1'b1, 5'd4,  32'h0,    1'b1, 1'b1, 32'hC000_0009);
      vt[7]  = mk(1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd12, 32'hCC,   1'b0, 1'b1, 32'hC000_0004);
      vt[8]  = mk(1'b0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  32'h0,    1'b1, 1'b0, 32'hC000_0004);
      vt[9]  = mk(1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 5'd21, 1'b1, 1'b1, 1'b1, 5'd21, 32'h0,    1'b0, 1'b0, 32'hC000_0004);
      vt[10] = mk(1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 5'd20, 32'h2020, 1'b0, 1'b1, 32'hC000_0015);
      vt[11] = mk(1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  32'h0,    1'b1, 1'b0, 32'hC000_0015);

      @(negedge clk);
      mdl_init = 1'b0;

      // Table: reset, single write/drain/read, read priority over drain
      for (int i = 0; i < 12; i++) begin
         drive(vt[i].rst, vt[i].wv, vt[i].wa, vt[i].wd, vt[i].rv, vt[i].ra);
         #1;
         chk($sformatf("v%0d.wr_ready", i), 32'(wr_ready), 32'(vt[i].e_wrr));
         chk($sformatf("v%0d.rd_ready", i), 32'(rd_ready), 32'(vt[i].e_rdr));
         chk($sformatf("v%0d.rf_we_", i), 32'(rf_we_), 32'(vt[i].e_we));
         chk($sformatf("v%0d.rf_addr", i), 32'(rf_addr), 32'(vt[i].e_rfa));
         if (vt[i].e_we == 1'b0 || vt[i].e_rdr == 1'b0)
            chk($sformatf("v%0d.rf_d_in", i), rf_d_in, vt[i].e_rfd);
         chk($sformatf("v%0d.idle", i), 32'(idle), 32'(vt[i].e_idle));
         chk($sformatf("v%0d.rd_data_valid", i), 32'(rd_data_valid), 32'(vt[i].e_rdv));
         chk($sformatf("v%0d.rd_data", i), rd_data, vt[i].e_rdd);
         @(negedge clk);
      end

      // Forwarding / stall: read of addr 7 held while 0x70 then 0x71 are queued
      drive(1'b0, 1'b1, 5'd7, 32'h70, 1'b1, 5'd7);
      #1;
      chk("fwd.a_rd_ready", 32'(rd_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b1, 5'd7, 32'h71, 1'b1, 5'd7);
      #1;
`ifdef REGFILE_WB_FWD_EN
      chk("fwd.b_rd_ready", 32'(rd_ready), 32'd1);
`else
      chk("fwd.b_rd_ready", 32'(rd_ready), 32'd0);
      chk("fwd.b_rf_we_", 32'(rf_we_), 32'd0);
      chk("fwd.b_rf_d_in", rf_d_in, 32'h70);
`endif
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         #1;
         if (rd_ready) begin
            got = 1'b1;
`ifdef REGFILE_WB_FWD_EN
            chk("fwd.c_idle", 32'(idle), 32'd0);
`else
            chk("fwd.c_idle", 32'(idle), 32'd1);
`endif
         end
         @(negedge clk);
      end
      chk("fwd.ready_seen", 32'(got), 32'd1);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1;
      chk("fwd.rd_data_valid", 32'(rd_data_valid), 32'd1);
      chk("fwd.rd_data", rd_data, 32'h71);
      @(negedge clk);
      wait_idle("fwd.drain_idle");
      chk("fwd.rf7_last_wins", rf_mem[7], 32'h71);

      // Full queue: reads held on a non-matching address until 4 writes queue up
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, 5'(k), 32'h100 + 32'(k), 1'b1, 5'd30);
         #1;
         chk($sformatf("full.w%0d_wr_ready", k), 32'(wr_ready), 32'd1);
         chk($sformatf("full.w%0d_rd_ready", k), 32'(rd_ready), 32'd1);
         @(negedge clk);
      end
      drive(1'b0, 1'b1, 5'd4, 32'h1FF, 1'b1, 5'd30);
      #1;
      chk("full.wr_ready", 32'(wr_ready), 32'd0);
      chk("full.rd_ready", 32'(rd_ready), 32'd0);
      chk("full.rf_we_", 32'(rf_we_), 32'd0);
      chk("full.rf_addr", 32'(rf_addr), 32'd0);
      chk("full.rf_d_in", rf_d_in, 32'h100);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd30);
      #1;
      chk("full.after_wr_ready", 32'(wr_ready), 32'd1);
      chk("full.after_rd_ready", 32'(rd_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      wait_idle("full.drain_idle");
      for (int k = 0; k < 4; k++)
         chk($sformatf("full.rf%0d", k), rf_mem[k], 32'h100 + 32'(k));
      chk("full.rf4_untouched", rf_mem[4], 32'hC000_0004);

      // Push+pop at count 2 across pointer wrap: 10 writes, data == addr
      drive(1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 5'd31);
      #1;
      chk("wrap.w0_rd_ready", 32'(rd_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 1'b1, 5'd1, 32'd1, 1'b1, 5'd31);
      #1;
      chk("wrap.w1_rd_ready", 32'(rd_ready), 32'd1);
      @(negedge clk);
      for (int k = 2; k < 10; k++) begin
         drive(1'b0, 1'b1, 5'(k), 32'(k), 1'b0, 5'd0);
         #1;
         chk($sformatf("wrap.w%0d_wr_ready", k), 32'(wr_ready), 32'd1);
         chk($sformatf("wrap.w%0d_rf_we_", k), 32'(rf_we_), 32'd0);
         chk($sformatf("wrap.w%0d_rf_addr", k), 32'(rf_addr), 32'(k - 2));
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1;
      chk("wrap.tail_rf_addr", 32'(rf_addr), 32'd8);
      @(negedge clk);
      wait_idle("wrap.drain_idle");
      for (int k = 0; k < 10; k++)
         chk($sformatf("wrap.rf%0d", k), rf_mem[k], 32'(k));

      // Reset with 3 queued entries: nothing reaches the regfile
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 5'(16 + k), 32'hDEAD_0000 + 32'(k), 1'b1, 5'd31);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd31);
      #1;
      chk("rstq.idle_before", 32'(idle), 32'd0);
      @(negedge clk);
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1;
      chk("rstq.rf_we_", 32'(rf_we_), 32'd1);
      chk("rstq.wr_ready", 32'(wr_ready), 32'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      #1;
      chk("rstq.idle_after", 32'(idle), 32'd1);
      chk("rstq.rf_we_after", 32'(rf_we_), 32'd1);
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         chk($sformatf("rstq.rf%0d", 16 + k), rf_mem[16 + k], 32'hC000_0010 + 32'(k));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/regfile_wb_buf.md
Name: regfile_wb_buf

Overview:
- Write-back buffer directly upstream of the single-port register file (regfile).
- Accepts write-back requests (valid/ready) and read requests, queues writes in a small FIFO, and owns the regfile's single addr/d_in/we_ port.
- Arbitrates each cycle between a read and the oldest pending write; forwards pending data to reads so software sees program-order values.

Parameters:
- ADDR_W, 5, regfile address width
- DATA_W, 32, regfile data width
- DEPTH, 4, write-queue entries (power of two, >=2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- wr_valid  in  1  write-back request valid
- wr_ready  out  1  buffer can accept a write this cycle
- wr_addr  in  ADDR_W  write-back register address
- wr_data  in  DATA_W  write-back data
- rd_valid  in  1  read request valid
- rd_ready  out  1  read accepted this cycle
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read result, registered
- rd_data_valid  out  1  one-cycle pulse, rd_data valid
- rf_addr  out  ADDR_W  to regfile addr
- rf_d_in  out  DATA_W  to regfile d_in
- rf_we_  out  1  to regfile we_, active-low
- rf_d_out  in  DATA_W  from regfile d_out (combinational read of rf_addr)
- idle  out  1  queue empty

Behaviour:
- One clock (clk); reset is synchronous, active-high.
- Reset: count=0, head/tail=0, rd_data=0, rd_data_valid=0. While reset is high: rf_we_=1, wr_ready=0, rd_ready=0. Reset mid-drain discards all queued entries; no regfile write occurs in the reset cycle.
- wr_ready = (count < DEPTH), based on registered count. No same-cycle pop bypass.
- Enqueue when wr_valid & wr_ready; entry goes at tail.
- Port arbitration, combinational each cycle:
  - READ: rd_valid & count<DEPTH & no stall. rd_ready=1, rf_addr=rd_addr, rf_we_=1.
  - DRAIN: otherwise if count>0. rf_addr=head.addr, rf_d_in=head.data, rf_we_=0; pop at the edge.
  - IDLE: rf_we_=1, rf_addr=0, rf_d_in=0.
  - Full queue (count==DEPTH) with rd_valid: DRAIN wins, rd_ready=0. This bounds write starvation.
- Read result:
  - Captured at the accepting edge; rd_data/rd_data_valid are valid the next cycle (latency 1).
  - Value is the youngest queued entry whose addr == rd_addr, if any; otherwise rf_d_out.
- Write enqueued in the same cycle as a read to the same address is not visible to that read.
- Simultaneous enqueue and drain: count unchanged, pointers both advance.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Multiple queued writes to one address drain in order; the last one wins in the regfile.
- idle = (count==0), combinational from register.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN
- Defined: forwarding as above.
- Undefined: no forwarding mux. A read whose rd_addr matches any queued entry stalls (rd_ready=0) and the cycle becomes DRAIN. Once no entry matches, the read proceeds from rf_d_out.

Decomposition:
- Shared package/header: ADDR_W/DATA_W defaults, ENABLE_/DISABLE_ (active-low 0/1), ENABLE/DISABLE, arbitration-state encoding (ARB_IDLE/ARB_READ/ARB_DRAIN).
- Sub-module regfile_wb_fifo: storage array, head/tail/count, push/pop, head outputs, and per-entry address match vector with youngest-match select.
- Top: arbitration, handshake, read register.

Test Plan:
- Reset: hold reset 2 cycles with wr_valid=1 -> rf_we_=1, wr_ready=0, idle=1, rd_data_valid=0; no regfile write after release.
- Single write/read: write addr 3 data 0x33 with no reads -> next cycle rf_we_=0, rf_addr=3, rf_d_in=0x33. Read addr 3 afterwards -> rd_data=0x33 one cycle later.
- Forwarding: hold rd_valid on addr 7 while enqueuing 0x70 then 0x71 to addr 7. The read issued the cycle after 0x71 enqueues returns 0x71 before any drain. Without REGFILE_WB_FWD_EN, rd_ready stays 0 until both entries drain, then returns 0x71.
- Full/starvation: enqueue DEPTH=4 writes (addrs 0..3) with rd_valid held -> wr_ready=0, rd_ready=0, drain proceeds; wr_ready returns the cycle after count drops to 3.
- Simultaneous push+pop at count=2 -> count stays 2; entries emerge in FIFO order across pointer wrap (issue 10 writes, check regfile addrs 0..9 each hold data==addr).
- Reset mid-drain with 3 entries queued -> entries discarded, idle=1, those addresses keep their old values.
